mem_responder: RTL and testbench

Memory-side responder for the data-cache refill/writeback interface. It accepts one word-sized read (line fill) or write (dirty writeback) request at a time from the cache over a valid/ready request channel. After a fixed, parameterised access latency it returns a response over a valid/ready response channel. It owns the backing word array and replaces the zero-latency data memory beneath the write-back cache, so cache miss handling can be exercised against realistic stalls.

---
 rtl/mem_responder.sv | 94 +++++++++
 tb/tb_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-array memory responder for cache refill/writeback: one request at a time,
// fixed access latency, registered response held until the cache consumes it.
module mem_responder #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned LATENCY        = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_wen_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [DATA_WIDTH-1:0]    resp_rdata_o,
  output logic                     resp_err_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                    state;
  logic [7:0]                cnt;
  logic                      wen_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic                      addr_err;
  logic                      access;
  logic                      mem_we;

  // Zero at simulation start; reset deliberately leaves the contents alone.
  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH] = '{default: '0};

  assign req_ready_o = rst_ni && (state == IDLE);
  assign busy_o      = (state != IDLE);

  always_comb begin
    idx      = addr_q[MEM_ADDR_WIDTH+1:2];
    addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (MEM_ADDR_WIDTH + 2)) != '0);
    access   = (state == WAIT) && (cnt == '0);
    // Gating with rst_ni keeps a reset on the access edge from committing the write.
    mem_we   = rst_ni && access && wen_q && !addr_err;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            wen_q   <= req_wen_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            cnt     <= 8'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            resp_valid_o <= 1'b1;
            resp_err_o   <= addr_err;
            resp_rdata_o <= (addr_err || wen_q) ? '0 : mem[idx];
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: two instances (LATENCY 4 and 1)
// checked against a word-array model with address legality computed arithmetically.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat [2]  = '{4, 1};
  logic [31:0] model [2][1024];

  always #5 clk = ~clk;

  mem_responder #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .LATENCY(4)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_wen_i(req_wen[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]), .busy_o(busy[0])
  );

  mem_responder #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_wen_i(req_wen[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]), .busy_o(busy[1])
  );

  // One full transaction on unit u; stall = cycles resp_ready is held low after valid.
  task automatic do_txn(input int u, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n;
    exp_err = (addr % 4 != 0) || (addr / 4 >= 1024);
    exp_rd  = '0;
    if (!exp_err) begin
      if (wen) model[u][addr / 4] = wdata;
      else     exp_rd = model[u][addr / 4];
    end
    @(negedge clk);
    req_valid[u]  = 1'b1;
    req_wen[u]    = wen;
    req_addr[u]   = addr;
    req_wdata[u]  = wdata;
    resp_ready[u] = (stall == 0);
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (req_ready[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL u%0d accept: req_ready=%b required 1", u, req_ready[u]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    n_checks++;
    if (busy[u] !== 1'b1 || req_ready[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL u%0d in_flight: busy=%b req_ready=%b required 1/0", u, busy[u], req_ready[u]);
    end
    n = 0;
    while (resp_valid[u] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != lat[u]) begin
      n_fail++;
      $display("FAIL u%0d latency addr=%h: got %0d cycles required %0d", u, addr, n, lat[u]);
    end
    if (stall > 0) begin
      req_valid[u] = 1'b1;
      req_wen[u]   = 1'b1;
      req_wdata[u] = ~wdata;
    end
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (resp_valid[u] !== 1'b1 || resp_rdata[u] !== exp_rd || resp_err[u] !== exp_err ||
          req_ready[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL u%0d resp addr=%h cyc%0d: valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                 u, addr, i, resp_valid[u], resp_rdata[u], resp_err[u], req_ready[u], exp_rd, exp_err);
      end
    end
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_valid[u] !== 1'b0 || busy[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL u%0d handshake: valid=%b busy=%b ready=%b required 0/0/1",
               u, resp_valid[u], busy[u], req_ready[u]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (req_ready[u] !== 1'b1 || resp_valid[u] !== 1'b0 || busy[u] !== 1'b0 ||
          resp_rdata[u] !== 32'h0 || resp_err[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL u%0d reset: ready=%b valid=%b busy=%b rdata=%h err=%b required 1/0/0/0/0",
                 u, req_ready[u], resp_valid[u], busy[u], resp_rdata[u], resp_err[u]);
      end
    end
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 0);
  endtask

  task automatic test_backpressure();
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 5);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 0);
  endtask

  task automatic test_errors();
    do_txn(0, 1'b1, 32'h0000_0000, 32'hA5A5_5A5A, 0);
    do_txn(0, 1'b0, 32'h0000_0012, 32'h0, 0);
    do_txn(0, 1'b1, 32'h0000_1000, 32'h1111_2222, 0);
    do_txn(0, 1'b0, 32'h0000_0000, 32'h0, 0);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    req_valid[0]  = 1'b1;
    req_wen[0]    = 1'b1;
    req_addr[0]   = 32'h0000_0020;
    req_wdata[0]  = 32'h1234_5678;
    resp_ready[0] = 1'b1;
    n_checks++;
    if (req_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst accept: req_ready=%b required 1", req_ready[0]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0 || resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst state: busy=%b valid=%b ready=%b required 0/0/0",
               busy[0], resp_valid[0], req_ready[0]);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst quiet cyc%0d: valid=%b busy=%b required 0/0", i, resp_valid[0], busy[0]);
      end
    end
    do_txn(0, 1'b0, 32'h0000_0020, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e0, e1;
    do_txn(1, 1'b1, 32'h0, $urandom, 0);
    do_txn(1, 1'b1, 32'h4, $urandom, 0);
    e0 = model[1][0];
    e1 = model[1][1];
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_wen[1]    = 1'b0;
    req_addr[1]   = 32'h0;
    resp_ready[1] = 1'b1;
    n_checks++;
    if (req_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b accept0: req_ready=%b required 1", req_ready[1]);
    end
    @(negedge clk);
    req_addr[1] = 32'h4;
    n_checks++;
    if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b k+0: valid=%b busy=%b required 0/1", resp_valid[1], busy[1]);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== e0 || resp_err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b resp0: valid=%b rdata=%h err=%b required 1/%h/0",
               resp_valid[1], resp_rdata[1], resp_err[1], e0);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b gap: valid=%b busy=%b ready=%b required 0/0/1",
               resp_valid[1], busy[1], req_ready[1]);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    n_checks++;
    if (busy[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b accept1: busy=%b valid=%b required 1/0", busy[1], resp_valid[1]);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== e1 || resp_err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b resp1: valid=%b rdata=%h err=%b required 1/%h/0",
               resp_valid[1], resp_rdata[1], resp_err[1], e1);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b done: valid=%b busy=%b required 0/0", resp_valid[1], busy[1]);
    end
  endtask

  task automatic test_random();
    int          u, r, stall;
    logic        wen;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      u     = int'($urandom_range(0, 1));
      wen   = 1'($urandom_range(0, 1));
      r     = int'($urandom_range(0, 9));
      stall = int'($urandom_range(0, 3));
      if (r < 6)       addr = $urandom_range(0, 15) * 4;
      else if (r == 6) addr = $urandom_range(1016, 1023) * 4;
      else if (r == 7) addr = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
      else if (r == 8) addr = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
      else             addr = 32'h0000_0FFC;
      do_txn(u, wen, addr, $urandom, stall);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 1024; a++) model[u][a] = '0;
      req_valid[u]  = 1'b0;
      req_wen[u]    = 1'b0;
      req_addr[u]   = '0;
      req_wdata[u]  = '0;
      resp_ready[u] = 1'b0;
    end
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
